// File: rtl/rtr_opc_credit_tracker_pkg.sv
// Shared router helpers: packet-class derivation, flat (port, class) indexing, counter width.
package rtr_opc_credit_tracker_pkg;

    function automatic int calc_packet_classes(input int num_msg, input int num_res);
        return num_msg * num_res;
    endfunction

    // Flat vector element for an (output port, packet class) pair.
    function automatic int flat_idx(input int op, input int opc, input int num_pc);
        return op * num_pc + opc;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rtr_opc_credit_tracker_entry.sv
// One (port, class) entry: saturating credit counter, allocation bit and registered flags.
// Check terms are only built when RTR_CREDIT_CHECK_EN is defined.
module rtr_opc_credit_entry #(
    parameter int buffer_size = 8,
    parameter int count_width = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic debit,
    input  logic credit,
    input  logic alloc_set,
    input  logic tail_clr,
    output logic credit_avail,
    output logic vc_free
`ifdef RTR_CREDIT_CHECK_EN
    ,
    output logic check_err
`endif
);

    localparam logic [count_width-1:0] full_count = count_width'(buffer_size);
    localparam logic [count_width-1:0] one_count  = count_width'(1);

    logic [count_width-1:0] count_reg;
    logic [count_width-1:0] count_next;
    logic                   alloc_reg;
    logic                   alloc_next;
    logic                   credit_avail_reg;
    logic                   vc_free_reg;

    // A same-cycle debit and credit cancel; otherwise move one step and saturate at both ends.
    always_comb begin
        count_next = count_reg;
        if (debit && !credit) begin
            if (count_reg != '0) begin
                count_next = count_reg - one_count;
            end
        end else if (credit && !debit) begin
            if (count_reg != full_count) begin
                count_next = count_reg + one_count;
            end
        end
    end

    // Set wins over tail clear: the next packet is allocated on the tail cycle.
    assign alloc_next = alloc_set | (alloc_reg & ~tail_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg        <= full_count;
            alloc_reg        <= 1'b0;
            credit_avail_reg <= 1'b1;
            vc_free_reg      <= 1'b1;
        end else begin
            count_reg        <= count_next;
            alloc_reg        <= alloc_next;
            credit_avail_reg <= (count_next != '0);
            vc_free_reg      <= !alloc_next && (count_next == full_count);
        end
    end

    assign credit_avail = credit_avail_reg;
    assign vc_free      = vc_free_reg;

`ifdef RTR_CREDIT_CHECK_EN
    assign check_err = (debit && (count_reg == '0))
                     | (credit && !debit && (count_reg == full_count))
                     | (alloc_set && alloc_reg && !tail_clr);
`endif

endmodule

// File: rtl/rtr_opc_credit_tracker.sv
// Output-side credit and VC-state tracker: one entry per (output port, packet class).
// Define RTR_CREDIT_CHECK_EN to build the sticky protocol/saturation error flag.
module rtr_opc_credit_tracker
    import rtr_opc_credit_tracker_pkg::*;
#(
    parameter int num_message_classes = 2,
    parameter int num_resource_classes = 2,
    parameter int num_ports = 5,
    parameter int buffer_size = 8,
    localparam int num_packet_classes = calc_packet_classes(num_message_classes, num_resource_classes),
    localparam int num_entries = num_ports * num_packet_classes
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alloc_valid,
    input  logic [0:num_ports-1]      alloc_op,
    input  logic [0:num_packet_classes-1] alloc_opc,
    input  logic                      debit_valid,
    input  logic [0:num_ports-1]      debit_op,
    input  logic [0:num_packet_classes-1] debit_opc,
    input  logic                      debit_tail,
    input  logic [0:num_entries-1]    cred_op_opc,
    output logic [0:num_entries-1]    credit_avail_op_opc,
    output logic [0:num_entries-1]    vc_free_op_opc,
    output logic                      error
);

    localparam int count_width = clog2(buffer_size + 1);

`ifdef RTR_CREDIT_CHECK_EN
    logic [0:num_entries-1] entry_err;
`endif

    // A malformed select updates every entry in the AND of port and class selects.
    for (genvar gi = 0; gi < num_ports; gi++) begin : g_port
        for (genvar gj = 0; gj < num_packet_classes; gj++) begin : g_class
            localparam int idx = flat_idx(gi, gj, num_packet_classes);
            logic debit_sel;
            logic alloc_sel;

            assign debit_sel = debit_valid & debit_op[gi] & debit_opc[gj];
            assign alloc_sel = alloc_valid & alloc_op[gi] & alloc_opc[gj];

            rtr_opc_credit_entry #(
                .buffer_size (buffer_size),
                .count_width (count_width)
            ) u_entry (
                .clk          (clk),
                .reset_n      (reset_n),
                .debit        (debit_sel),
                .credit       (cred_op_opc[idx]),
                .alloc_set    (alloc_sel),
                .tail_clr     (debit_sel & debit_tail),
                .credit_avail (credit_avail_op_opc[idx]),
                .vc_free      (vc_free_op_opc[idx])
`ifdef RTR_CREDIT_CHECK_EN
                ,
                .check_err    (entry_err[idx])
`endif
            );
        end
    end

`ifdef RTR_CREDIT_CHECK_EN
    logic select_err;
    logic error_reg;

    assign select_err = (alloc_valid && !($onehot(alloc_op) && $onehot(alloc_opc)))
                      | (debit_valid && !($onehot(debit_op) && $onehot(debit_opc)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= error_reg | select_err | (|entry_err);
        end
    end

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

endmodule
